// File: rtl/macc_pkg.sv
// Shared types and constants for the matrix RAM read/write datapath blocks.
package macc_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 12;
  localparam int DEFAULT_DIM = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              row_end;
    logic              last;
  } fifo_entry_t;

  // Tags ride alongside an outstanding read until its data returns.
  typedef struct packed {
    logic vld;
    logic row_end;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/macc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; push and pop may
// coincide at any occupancy (a pop frees the slot the same cycle).
module macc_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop, full;

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/matrix_stream_reader.sv
// Reads a full matrix from a fixed-latency RAM under FIFO credit and replays it as a
// row-major valid/ready stream with row-end (m_tuser) and last (m_tlast) markers.
//
// state | meaning
// IDLE  | waiting for start; the first read is issued in the start cycle
// ISSUE | issuing reads while in-flight + buffered words leave FIFO room
// DRAIN | every read issued; waiting for the last word to handshake
module matrix_stream_reader
  import macc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ROWS       = 64,
  parameter int COLS       = 64,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_L,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ren,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_W + 2;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [NW-1:0] inflight_q, inflight_d;
  rd_tag_t       pipe_q [RD_LAT];
  logic          done_q, done_d;
  logic          issue, credit, cur_row_end, cur_last, ret, pop, fifo_empty;
  logic [NW-1:0] fifo_count;
  logic [EW-1:0] push_data, head;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      pipe_q[0]  <= rd_tag_t'{vld: issue, row_end: cur_row_end, last: cur_last};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Credit uses registered counts only, so a read is never issued without a slot.
  assign credit = (int'(inflight_q) + int'(fifo_count)) < FIFO_DEPTH;
  assign ret    = pipe_q[RD_LAT-1].vld;
  assign pop    = m_tvalid && m_tready;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    issue       = 1'b0;
    cur_row     = (state_q == IDLE) ? '0 : row_q;
    cur_col     = (state_q == IDLE) ? '0 : col_q;
    cur_row_end = (cur_col == CW'(COLS - 1));
    cur_last    = cur_row_end && (cur_row == RW'(ROWS - 1));
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: issue = credit;
      DRAIN: begin
        if (pop && head[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (cur_last) state_d = DRAIN;
      if (cur_row_end) begin
        col_d = '0;
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
    inflight_d = inflight_q + NW'(issue) - NW'(ret);
  end

  assign push_data = {rd_data, pipe_q[RD_LAT-1].row_end, pipe_q[RD_LAT-1].last};

  macc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_L),
    .push_i  (ret),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    ren      = issue;
    m_tvalid = !fifo_empty;
    m_tdata  = head[EW-1:2];
    m_tuser  = m_tvalid && head[1];
    m_tlast  = m_tvalid && head[0];
  end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Scoreboard bench: three reader instances (4x4/lat1, 1x1/lat1, 64x64/lat2) each fed
// by a behavioural RAM whose word i holds 0xA000_0000+i.
module tb_matrix_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic        a_rst, a_start, a_busy, a_done, a_ren, a_tvalid, a_tready, a_tuser, a_tlast;
  logic [31:0] a_rd, a_tdata;
  logic        s_rst, s_start, s_busy, s_done, s_ren, s_tvalid, s_tready, s_tuser, s_tlast;
  logic [31:0] s_rd, s_tdata;
  logic        l_rst, l_start, l_busy, l_done, l_ren, l_tvalid, l_tready, l_tuser, l_tlast;
  logic [31:0] l_rd, l_tdata, l_s1;
  logic [11:0] a_addr, s_addr, l_addr;

  matrix_stream_reader #(.DATA_W(32), .ROWS(4), .COLS(4), .RD_LAT(1), .FIFO_DEPTH(4)) dut_a (
    .CLK(clk), .RST_L(a_rst), .start(a_start), .busy(a_busy), .done(a_done), .ren(a_ren),
    .rd_data(a_rd), .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(a_tready),
    .m_tuser(a_tuser), .m_tlast(a_tlast));

  matrix_stream_reader #(.DATA_W(32), .ROWS(1), .COLS(1), .RD_LAT(1), .FIFO_DEPTH(4)) dut_s (
    .CLK(clk), .RST_L(s_rst), .start(s_start), .busy(s_busy), .done(s_done), .ren(s_ren),
    .rd_data(s_rd), .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(s_tready),
    .m_tuser(s_tuser), .m_tlast(s_tlast));

  matrix_stream_reader #(.DATA_W(32), .ROWS(64), .COLS(64), .RD_LAT(2), .FIFO_DEPTH(4)) dut_l (
    .CLK(clk), .RST_L(l_rst), .start(l_start), .busy(l_busy), .done(l_done), .ren(l_ren),
    .rd_data(l_rd), .m_tdata(l_tdata), .m_tvalid(l_tvalid), .m_tready(l_tready),
    .m_tuser(l_tuser), .m_tlast(l_tlast));

  // RAM models: address clears on an accepted start, advances on every ren.
  always @(posedge clk) begin
    if (a_ren) a_addr <= ((a_start && !a_busy) ? 12'd0 : a_addr) + 12'd1;
    a_rd <= 32'hA000_0000 + 32'((a_start && !a_busy) ? 12'd0 : a_addr);
    if (s_ren) s_addr <= ((s_start && !s_busy) ? 12'd0 : s_addr) + 12'd1;
    s_rd <= 32'hA000_0000 + 32'((s_start && !s_busy) ? 12'd0 : s_addr);
    if (l_ren) l_addr <= ((l_start && !l_busy) ? 12'd0 : l_addr) + 12'd1;
    l_s1 <= 32'hA000_0000 + 32'((l_start && !l_busy) ? 12'd0 : l_addr);
    l_rd <= l_s1;
  end

  logic [33:0] qa[$], qs[$], ql[$];
  int ren_cnt[3], hs_cnt[3], first_v[3], first_hs[3], last_hs[3], start_cyc[3];
  bit prev_last[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return qa.size();
      1: return qs.size();
      default: return ql.size();
    endcase
  endfunction

  task automatic clear(input int id);
    ren_cnt[id] = 0; hs_cnt[id] = 0; first_v[id] = -1;
    first_hs[id] = -1; last_hs[id] = -1; prev_last[id] = 0;
  endtask

  task automatic mon(input int id, input logic tv, input logic tr, input logic tu,
                     input logic tl, input logic [31:0] td, input logic dn, input logic rn);
    logic [33:0] e;
    if (rn) ren_cnt[id]++;
    chk($sformatf("done%0d", id), 64'(dn), 64'(prev_last[id]));
    prev_last[id] = 0;
    if (tv && first_v[id] < 0) first_v[id] = cyc;
    if (tv && tr) begin
      if (qsize(id) == 0) chk($sformatf("extra_word%0d", id), 64'(td), 64'hDEAD);
      else begin
        case (id)
          0: e = qa.pop_front();
          1: e = qs.pop_front();
          default: e = ql.pop_front();
        endcase
        chk($sformatf("word%0d_%0d", id, hs_cnt[id]), 64'({td, tu, tl}), 64'(e));
      end
      if (hs_cnt[id] == 0) first_hs[id] = cyc;
      last_hs[id] = cyc;
      hs_cnt[id]++;
      if (tl) prev_last[id] = 1;
    end
    chk($sformatf("credit%0d", id), 64'((ren_cnt[id] - hs_cnt[id]) <= 4), 64'd1);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (a_start && !a_busy) start_cyc[0] = cyc;
    if (s_start && !s_busy) start_cyc[1] = cyc;
    if (l_start && !l_busy) start_cyc[2] = cyc;
    mon(0, a_tvalid, a_tready, a_tuser, a_tlast, a_tdata, a_done, a_ren);
    mon(1, s_tvalid, s_tready, s_tuser, s_tlast, s_tdata, s_done, s_ren);
    mon(2, l_tvalid, l_tready, l_tuser, l_tlast, l_tdata, l_done, l_ren);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int id, input int rows, input int cols);
    int n;
    n = rows * cols;
    clear(id);
    for (int i = 0; i < n; i++) begin
      logic [33:0] e;
      e = {32'hA000_0000 + 32'(i), ((i % cols) == cols - 1), (i == n - 1)};
      case (id)
        0: qa.push_back(e);
        1: qs.push_back(e);
        default: ql.push_back(e);
      endcase
    end
    case (id)
      0: a_start = 1'b1;
      1: s_start = 1'b1;
      default: l_start = 1'b1;
    endcase
    tick();
    a_start = 1'b0; s_start = 1'b0; l_start = 1'b0;
  endtask

  task automatic run_out(input int id, input int limit);
    for (int i = 0; i < limit && qsize(id) != 0; i++) tick();
    chk($sformatf("timeout%0d", id), 64'(qsize(id)), 64'd0);
    tick();
  endtask

  initial begin
    a_rst = 0; s_rst = 0; l_rst = 0;
    a_start = 0; s_start = 0; l_start = 0;
    a_tready = 1; s_tready = 1; l_tready = 1;
    for (int i = 0; i < 3; i++) clear(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'({a_busy, a_done, a_ren, a_tvalid, a_tuser, a_tlast}), 64'd0);
    chk("rst_data", 64'(a_tdata), 64'd0);
    a_rst = 1; s_rst = 1; l_rst = 1;
    tick();

    // 1: straight read, no backpressure
    do_start(0, 4, 4);
    run_out(0, 100);
    chk("t1_latency", 64'(first_v[0] - start_cyc[0]), 64'd2);
    chk("t1_contig", 64'(last_hs[0] - first_hs[0]), 64'd15);
    chk("t1_ren", 64'(ren_cnt[0]), 64'd16);
    chk("t1_busy", 64'(a_busy), 64'd0);

    // 2: random ready at ~30%
    do_start(0, 4, 4);
    for (int i = 0; i < 600 && qa.size() != 0; i++) begin
      a_tready = ($urandom_range(0, 9) < 3);
      tick();
    end
    a_tready = 1;
    chk("t2_left", 64'(qa.size()), 64'd0);
    tick();
    chk("t2_ren", 64'(ren_cnt[0]), 64'd16);
    chk("t2_hs", 64'(hs_cnt[0]), 64'd16);

    // 3: full stall after start
    a_tready = 0;
    do_start(0, 4, 4);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_tvalid) chk("t3_hold", 64'(a_tdata), 64'hA000_0000);
    end
    chk("t3_ren", 64'(ren_cnt[0]), 64'd4);
    chk("t3_valid", 64'(a_tvalid), 64'd1);
    a_tready = 1;
    run_out(0, 100);
    chk("t3_ren_total", 64'(ren_cnt[0]), 64'd16);

    // 4: 1x1 matrix
    do_start(1, 1, 1);
    run_out(1, 50);
    chk("t4_ren", 64'(ren_cnt[1]), 64'd1);
    chk("t4_latency", 64'(first_v[1] - start_cyc[1]), 64'd2);
    chk("t4_busy", 64'(s_busy), 64'd0);

    // 5: start while busy is ignored, then reset mid-transfer
    do_start(0, 4, 4);
    for (int i = 0; i < 100 && hs_cnt[0] < 5; i++) tick();
    a_start = 1;
    tick();
    a_start = 0;
    run_out(0, 100);
    chk("t5_hs", 64'(hs_cnt[0]), 64'd16);
    chk("t5_ren", 64'(ren_cnt[0]), 64'd16);
    do_start(0, 4, 4);
    for (int i = 0; i < 100 && hs_cnt[0] < 8; i++) tick();
    chk("t5_reach8", 64'(hs_cnt[0]), 64'd8);
    a_rst = 0;
    #1;
    chk("t5_rst_out", 64'({a_busy, a_done, a_ren, a_tvalid, a_tuser, a_tlast}), 64'd0);
    chk("t5_rst_data", 64'(a_tdata), 64'd0);
    qa.delete();
    clear(0);
    tick();
    tick();
    a_rst = 1;
    tick();
    do_start(0, 4, 4);
    run_out(0, 100);
    chk("t5_restart_hs", 64'(hs_cnt[0]), 64'd16);

    // 6: 64x64 with RD_LAT=2
    do_start(2, 64, 64);
    run_out(2, 5000);
    chk("t6_latency", 64'(first_v[2] - start_cyc[2]), 64'd3);
    chk("t6_contig", 64'(last_hs[2] - first_hs[2]), 64'd4095);
    chk("t6_ren", 64'(ren_cnt[2]), 64'd4096);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_stream_reader.md
Name: matrix_stream_reader

Overview:
- Read-side companion to the matrix write path: the write path fills a matrix RAM word by word through a per-matrix `wen` and an auto-incrementing address controller.
- This block drives the matching `ren` strobe, captures the RAM's fixed-latency read data, and emits the matrix as a valid/ready stream in row-major order with row-end and last markers.
- Sits between a matrix RAM datapath (A, B or C) and a DMA/AXI-stream egress.
- Backpressure never loses or duplicates a word.

Parameters:
- DATA_W, 32, stream and RAM data width
- ROWS, 64, matrix rows per transfer (1..4096)
- COLS, 64, matrix columns per row (1..4096; ROWS*COLS <= 4096)
- RD_LAT, 1, RAM read latency in cycles from `ren` to valid `rd_data` (1 or 2)
- FIFO_DEPTH, 4, output buffer depth in words (must be >= RD_LAT+1, power of 2)

Ports:
- CLK, input, 1, clock
- RST_L, input, 1, reset: asynchronous assert, active-low
- start, input, 1, one-cycle pulse that begins a full-matrix read; ignored unless idle
- busy, output, 1, high from the accepted start until the last word handshakes
- done, output, 1, one-cycle pulse in the cycle after the last word handshakes
- ren, output, 1, read strobe to the matrix controller/RAM; each pulse advances the RAM address by one
- rd_data, input, DATA_W, RAM read data, valid RD_LAT cycles after `ren`
- m_tdata, output, DATA_W, stream data
- m_tvalid, output, 1, stream valid
- m_tready, input, 1, stream ready
- m_tuser, output, 1, high on the last word of each row (column index == COLS-1)
- m_tlast, output, 1, high on the final word of the matrix

Behaviour:
- Reset values: `busy`=0, `done`=0, `ren`=0, `m_tvalid`=0, `m_tuser`=0, `m_tlast`=0, `m_tdata`=0; FIFO empty, counters 0, FSM in IDLE.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on `start`, go to ISSUE; `busy`=1 from the next cycle; clear issue counters.
  - ISSUE: assert `ren` in any cycle where (in_flight + fifo_count) < FIFO_DEPTH.
    - in_flight counts `ren` pulses not yet returned; it is 0..RD_LAT.
    - The credit check uses registered counts, so it never overflows the FIFO.
    - After the ROWS*COLS-th `ren`, go to DRAIN.
  - DRAIN: no `ren`. Once the word with `m_tlast`=1 handshakes (`m_tvalid` && `m_tready`), go to IDLE, pulse `done` next cycle, drop `busy` the same cycle `done` rises.
- Exactly ROWS*COLS `ren` pulses per transfer; the address controller resets to 0 between transfers externally.
- Return path:
  - An RD_LAT-deep shift register of valid bits tracks each `ren`.
  - When the tap fires, push `rd_data` into the FIFO together with a row-end tag and a last tag, both computed at issue time from the row/col counters and piped alongside.
- Counters:
  - col counts 0..COLS-1 and wraps to 0 while row increments.
  - Issue is complete when row==ROWS-1 && col==COLS-1 has been issued.
  - Widths are clog2 of the dimensions, minimum 1 bit.
- Output:
  - `m_tvalid` = FIFO not empty; `m_tdata`/`m_tuser`/`m_tlast` come from the FIFO head (first-word fall-through).
  - Data is stable while `m_tvalid` && !`m_tready`.
- Throughput: with `m_tready` held high, one word per cycle sustained; first `m_tvalid` RD_LAT+1 cycles after the `start` cycle.
- Simultaneous FIFO push and pop: allowed at any occupancy, including full (a pop frees space that cycle) and empty (no fall-through bypass; data appears next cycle).
- COLS=1: every word has `m_tuser`=1. ROWS=COLS=1: the single word has `m_tuser`=`m_tlast`=1.
- `start` while `busy`: ignored, no effect on counters.
- Reset mid-transfer: all state clears asynchronously; no `done`; outstanding RAM reads are discarded.

Decomposition:
- macc_pkg holds:
  - constants: DATA_W=32, ADDR_W=12, DEFAULT_DIM=64
  - the FSM state typedef: IDLE/ISSUE/DRAIN
  - a FIFO entry struct: data, row-end, last
- One sub-module: macc_sync_fifo, a parameterised width/depth first-word-fall-through FIFO with `count` output, asynchronous active-low reset, and push/pop allowed in the same cycle.

Test Plan:
1. Data order, no backpressure: ROWS=4, COLS=4, RAM preloaded with word i = 32'hA000_0000+i, `m_tready`=1.
   - 16 words 0xA0000000..0xA000000F, contiguous, one per cycle.
   - `m_tuser` on i=3,7,11,15; `m_tlast` on i=15 only.
   - `done` one cycle after the i=15 handshake.
2. Backpressure: same setup, `m_tready` random at 30% duty.
   - Identical 16-word sequence, no drops or duplicates.
   - `ren` count == 16; FIFO never exceeds FIFO_DEPTH (assertion).
3. Stall: `m_tready`=0 for 50 cycles after `start`.
   - Exactly FIFO_DEPTH `ren` pulses, then `ren` held low.
   - `m_tdata`=0xA0000000 stable; on release, the stream completes correctly.
4. Degenerate size: ROWS=1, COLS=1 → one `ren`; one word with `m_tuser`=`m_tlast`=1; `done` pulse.
5. Start and reset handling:
   - `start` re-pulsed at word 5: ignored, still 16 words total.
   - Then `RST_L` low mid-transfer at word 8: all outputs 0 immediately.
   - A new `start` after release reads 16 words from 0xA0000000.
6. RD_LAT=2, FIFO_DEPTH=4, 64x64 with `m_tready`=1: 4096 words in order, sustained one per cycle after a 3-cycle startup.
